// File: rtl/noc_tree_router.sv
// Three-port binary-tree NoC router: parent/child1/child2 inputs, each with a 2-entry FIFO,
// round-robin arbitration into 1-entry output registers. NOC_ROUTER_ERRCNT_EN adds err_count.
module noc_tree_router #(
    parameter int                    WIDTH_PACKET = 14,
    parameter int                    WIDTH_DEST   = 3,
    parameter int                    LEVEL        = 2,
    parameter logic [WIDTH_DEST-1:0] ROUTER_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    parent_in_valid,
    input  logic [WIDTH_PACKET-1:0] parent_in_data,
    output logic                    parent_in_ready,
    input  logic                    child1_in_valid,
    input  logic [WIDTH_PACKET-1:0] child1_in_data,
    output logic                    child1_in_ready,
    input  logic                    child2_in_valid,
    input  logic [WIDTH_PACKET-1:0] child2_in_data,
    output logic                    child2_in_ready,
    output logic                    parent_out_valid,
    output logic [WIDTH_PACKET-1:0] parent_out_data,
    input  logic                    parent_out_ready,
    output logic                    child1_out_valid,
    output logic [WIDTH_PACKET-1:0] child1_out_data,
    input  logic                    child1_out_ready,
    output logic                    child2_out_valid,
    output logic [WIDTH_PACKET-1:0] child2_out_data,
    input  logic                    child2_out_ready
`ifdef NOC_ROUTER_ERRCNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    // Handshake: a word moves on a rising edge where valid and ready are both high; a sender
    // holds valid and data until that edge, and out_data stays frozen while stalled.
    localparam int NP = 3;
    localparam logic [1:0] TO_PARENT = 2'd0;
    localparam logic [1:0] TO_CHILD1 = 2'd1;
    localparam logic [1:0] TO_CHILD2 = 2'd2;
    localparam logic [1:0] TO_DROP   = 2'd3;
    // Port index 0 = parent, 1 = child1, 2 = child2; A is the candidate preferred after reset.
    localparam int CAND_A [NP] = '{1, 0, 0};
    localparam int CAND_B [NP] = '{2, 2, 1};

    function automatic logic [1:0] route_of(input int src, input logic [WIDTH_DEST-1:0] dest);
        logic in_sub;
        logic sel;
        in_sub = (dest >> LEVEL) == (ROUTER_ADDR >> LEVEL);
        sel    = dest[LEVEL-1];
        if (src == 0)      route_of = sel ? TO_CHILD2 : TO_CHILD1;
        else if (!in_sub)  route_of = TO_PARENT;
        else if (src == 1) route_of = sel ? TO_CHILD2 : TO_DROP;
        else               route_of = sel ? TO_DROP : TO_CHILD1;
    endfunction

    logic [NP-1:0]           in_valid, in_ready, in_push, out_ready;
    logic [WIDTH_PACKET-1:0] in_data [NP];

    logic [WIDTH_PACKET-1:0] fifo_q [NP][2];
    logic [NP-1:0]           rd_ptr_q, wr_ptr_q;
    logic [1:0]              cnt_q [NP];
    logic [1:0]              cnt_d [NP];
    logic                    live_q;

    logic [WIDTH_PACKET-1:0] head [NP];
    logic [1:0]              route [NP];
    logic [NP-1:0]           head_valid, drop, pop;

    logic [NP-1:0]           req_a, req_b, grant_a, grant_b, load_ok, load;
    logic [NP-1:0]           rr_q, rr_d, ov_q;
    logic [WIDTH_PACKET-1:0] od_q [NP];
    logic [WIDTH_PACKET-1:0] load_data [NP];

    assign in_valid  = {child2_in_valid, child1_in_valid, parent_in_valid};
    assign in_data[0] = parent_in_data;
    assign in_data[1] = child1_in_data;
    assign in_data[2] = child2_in_data;
    assign out_ready = {child2_out_ready, child1_out_ready, parent_out_ready};

    assign parent_in_ready  = in_ready[0];
    assign child1_in_ready  = in_ready[1];
    assign child2_in_ready  = in_ready[2];
    assign parent_out_valid = ov_q[0];
    assign parent_out_data  = od_q[0];
    assign child1_out_valid = ov_q[1];
    assign child1_out_data  = od_q[1];
    assign child2_out_valid = ov_q[2];
    assign child2_out_data  = od_q[2];

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            head[i]       = fifo_q[i][rd_ptr_q[i]];
            head_valid[i] = cnt_q[i] != 2'd0;
            route[i]      = route_of(i, head[i][WIDTH_PACKET-1 -: WIDTH_DEST]);
            drop[i]       = head_valid[i] && (route[i] == TO_DROP);
            // live_q keeps ready low until the first edge after reset release.
            in_ready[i]   = live_q && (cnt_q[i] != 2'd2);
            in_push[i]    = in_valid[i] && in_ready[i];
        end
    end

    always_comb begin
        pop  = drop;
        rr_d = rr_q;
        for (int o = 0; o < NP; o++) begin
            req_a[o]     = head_valid[CAND_A[o]] && (route[CAND_A[o]] == 2'(o));
            req_b[o]     = head_valid[CAND_B[o]] && (route[CAND_B[o]] == 2'(o));
            load_ok[o]   = !ov_q[o] || out_ready[o];
            grant_a[o]   = load_ok[o] && req_a[o] && (!req_b[o] || !rr_q[o]);
            grant_b[o]   = load_ok[o] && req_b[o] && !grant_a[o];
            load[o]      = grant_a[o] || grant_b[o];
            load_data[o] = grant_a[o] ? head[CAND_A[o]] : head[CAND_B[o]];
            if (grant_a[o]) begin
                pop[CAND_A[o]] = 1'b1;
                rr_d[o]        = 1'b1;
            end
            if (grant_b[o]) begin
                pop[CAND_B[o]] = 1'b1;
                rr_d[o]        = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            case ({in_push[i], pop[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + 2'd1;
                2'b01:   cnt_d[i] = cnt_q[i] - 2'd1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rr_q     <= '0;
            ov_q     <= '0;
            for (int i = 0; i < NP; i++) begin
                cnt_q[i]     <= 2'd0;
                od_q[i]      <= '0;
                fifo_q[i][0] <= '0;
                fifo_q[i][1] <= '0;
            end
        end else begin
            live_q <= 1'b1;
            rr_q   <= rr_d;
            for (int i = 0; i < NP; i++) begin
                if (in_push[i]) begin
                    fifo_q[i][wr_ptr_q[i]] <= in_data[i];
                    wr_ptr_q[i]            <= ~wr_ptr_q[i];
                end
                if (pop[i]) rd_ptr_q[i] <= ~rd_ptr_q[i];
                cnt_q[i] <= cnt_d[i];
            end
            for (int o = 0; o < NP; o++) begin
                if (load[o]) begin
                    ov_q[o] <= 1'b1;
                    od_q[o] <= load_data[o];
                end else if (out_ready[o]) begin
                    ov_q[o] <= 1'b0;
                end
            end
        end
    end

`ifdef NOC_ROUTER_ERRCNT_EN
    logic [7:0] err_q, err_d;
    logic [9:0] err_sum;

    // Both children may drop in the same cycle, so the increment can be 2.
    always_comb begin
        err_sum = {2'b00, err_q} + 10'(drop[1]) + 10'(drop[2]);
        err_d   = (err_sum > 10'd255) ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 8'd0;
        else        err_q <= err_d;
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_noc_tree_router.sv
// Self-checking bench for noc_tree_router (LEVEL=2, ROUTER_ADDR=0): directed scenarios with
// literal expectations plus randomized traffic checked by a per-(output,source) scoreboard.
module tb_noc_tree_router;
  localparam int WP = 14;
  localparam int WD = 3;
  localparam int LV = 2;
  localparam int RA = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] in_valid = '0;
  logic [WP-1:0] in_data [3];
  logic [2:0] in_ready;
  logic [2:0] out_valid;
  logic [WP-1:0] out_data [3];
  logic [2:0] out_ready = 3'b111;
`ifdef NOC_ROUTER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int checks = 0;
  int errors = 0;
  int drops = 0;
  logic [WP+1:0] exp_q[$];
  logic [WP-1:0] c1_log[$];
  logic [2:0] acc = '0;
  logic [2:0] prev_stall = '0;
  logic [WP-1:0] prev_data [3];
  logic [8:0] seq [3];

  noc_tree_router #(
    .WIDTH_PACKET(WP), .WIDTH_DEST(WD), .LEVEL(LV), .ROUTER_ADDR(3'b000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .parent_in_valid(in_valid[0]), .parent_in_data(in_data[0]), .parent_in_ready(in_ready[0]),
    .child1_in_valid(in_valid[1]), .child1_in_data(in_data[1]), .child1_in_ready(in_ready[1]),
    .child2_in_valid(in_valid[2]), .child2_in_data(in_data[2]), .child2_in_ready(in_ready[2]),
    .parent_out_valid(out_valid[0]), .parent_out_data(out_data[0]), .parent_out_ready(out_ready[0]),
    .child1_out_valid(out_valid[1]), .child1_out_data(out_data[1]), .child1_out_ready(out_ready[1]),
    .child2_out_valid(out_valid[2]), .child2_out_data(out_data[2]), .child2_out_ready(out_ready[2])
`ifdef NOC_ROUTER_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  // Returns 0 parent, 1 child1, 2 child2, 3 drop, from leaf-index arithmetic.
  function automatic int model_route(input int src, input logic [WD-1:0] dest);
    int d;
    int half;
    d = int'(dest);
    half = d / (1 << (LV - 1));
    if (src == 0) return (half % 2 == 0) ? 1 : 2;
    if (d / (1 << LV) != RA / (1 << LV)) return 0;
    if (src == 1) return (half % 2 == 1) ? 2 : 3;
    return (half % 2 == 0) ? 1 : 3;
  endfunction

  function automatic logic [WP-1:0] mk(input logic [2:0] dest, input int src, input logic [8:0] s);
    return {dest, 2'(src), s};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic sb_check(input int o, input logic [WP-1:0] d);
    int k;
    k = -1;
    for (int j = 0; j < exp_q.size(); j++) begin
      if (k < 0 && int'(exp_q[j][WP+1:WP]) == o && exp_q[j][10:9] == d[10:9]) k = j;
    end
    checks++;
    if (k < 0) begin
      errors++;
      $display("FAIL sb_unexpected out%0d: got %h, expected no transfer", o, d);
    end else begin
      if (exp_q[k][WP-1:0] !== d) begin
        errors++;
        $display("FAIL sb_data out%0d: got %h, expected %h", o, d, exp_q[k][WP-1:0]);
      end
      exp_q.delete(k);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = '0;
      acc = '0;
    end else begin
      for (int o = 0; o < 3; o++) begin
        if (prev_stall[o]) begin
          checks++;
          if (!out_valid[o] || out_data[o] !== prev_data[o]) begin
            errors++;
            $display("FAIL hold_stable out%0d: got v=%0b d=%h, expected v=1 d=%h",
                     o, out_valid[o], out_data[o], prev_data[o]);
          end
        end
        if (out_valid[o] && out_ready[o]) begin
          sb_check(o, out_data[o]);
          if (o == 1) c1_log.push_back(out_data[o]);
        end
        prev_stall[o] = out_valid[o] && !out_ready[o];
        prev_data[o] = out_data[o];
      end
      for (int i = 0; i < 3; i++) begin
        int r;
        acc[i] = in_valid[i] && in_ready[i];
        if (acc[i]) begin
          r = model_route(i, in_data[i][WP-1 -: WD]);
          if (r == 3) drops++;
          else exp_q.push_back({2'(r), in_data[i]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int port, input logic [WP-1:0] d);
    bit done;
    done = 0;
    in_valid[port] = 1'b1;
    in_data[port] = d;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready[port]) done = 1;
    end
    @(posedge clk); #1;
    in_valid[port] = 1'b0;
    if (!done) check("send_timeout", 32'(port), 32'hFFFF_FFFF);
  endtask

  task automatic mid_reset();
    #2;
    in_valid = '0;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_data0", 32'(out_data[0]), 32'h0);
    check("rst_out_data2", 32'(out_data[2]), 32'h0);
`ifdef NOC_ROUTER_ERRCNT_EN
    check("rst_err_count", 32'(err_count), 32'h0);
`endif
    exp_q.delete();
    drops = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_rel_ready_low", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    check("rst_rel_ready_high", 32'(in_ready), 32'h7);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      in_data[i] = '0;
      seq[i] = '0;
    end
    repeat (2) @(posedge clk); #1;
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h0);
    check("reset_out_data1", 32'(out_data[1]), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", 32'(in_ready), 32'h7);

    // Parent to dest 011: child2_out two edges after acceptance.
    in_valid[0] = 1'b1;
    in_data[0] = 14'h1805;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("p2c2_not_early", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    check("p2c2_valid", 32'(out_valid), 32'h4);
    check("p2c2_data", 32'(out_data[2]), 32'h1805);
    repeat (3) @(posedge clk); #1;

    // Both children to parent on the same edge: child1 first, then child2.
    in_valid[1] = 1'b1; in_data[1] = 14'h2A01;
    in_valid[2] = 1'b1; in_data[2] = 14'h2C02;
    @(posedge clk); #1;
    in_valid[1] = 1'b0; in_valid[2] = 1'b0;
    @(posedge clk); #1;
    check("rr_first_valid", 32'(out_valid[0]), 32'h1);
    check("rr_first_data", 32'(out_data[0]), 32'h2A01);
    @(posedge clk); #1;
    check("rr_second_valid", 32'(out_valid[0]), 32'h1);
    check("rr_second_data", 32'(out_data[0]), 32'h2C02);
    repeat (3) @(posedge clk); #1;

    // child1 out-of-subtree goes up; in-subtree sel=1 goes across.
    send(1, 14'h2A03);
    @(posedge clk); #1;
    check("c1_up_valid", 32'(out_valid), 32'h1);
    check("c1_up_data", 32'(out_data[0]), 32'h2A03);
    send(1, 14'h1204);
    @(posedge clk); #1;
    check("c1_across_valid", 32'(out_valid), 32'h4);
    check("c1_across_data", 32'(out_data[2]), 32'h1204);
    repeat (3) @(posedge clk); #1;

    // Backpressure on child1_out: parent_in_ready drops after the 3rd packet.
    c1_log.delete();
    out_ready[1] = 1'b0;
    send(0, 14'h0010);
    send(0, 14'h0811);
    send(0, 14'h0012);
    check("bp_ready_low", 32'(in_ready[0]), 32'h0);
    in_valid[0] = 1'b1;
    in_data[0] = 14'h0813;
    repeat (4) @(posedge clk); #1;
    check("bp_still_low", 32'(in_ready[0]), 32'h0);
    out_ready[1] = 1'b1;
    for (int t = 0; t < 20 && in_valid[0]; t++) begin
      @(negedge clk);
      if (in_ready[0]) begin
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
      end
    end
    for (int t = 0; t < 20 && c1_log.size() < 4; t++) @(posedge clk);
    #1;
    check("bp_count", 32'(c1_log.size()), 32'd4);
    if (c1_log.size() == 4) begin
      check("bp_order0", 32'(c1_log[0]), 32'h0010);
      check("bp_order1", 32'(c1_log[1]), 32'h0811);
      check("bp_order2", 32'(c1_log[2]), 32'h0012);
      check("bp_order3", 32'(c1_log[3]), 32'h0813);
    end
    repeat (2) @(posedge clk); #1;

`ifdef NOC_ROUTER_ERRCNT_EN
    // Misroute drop from child1, then saturation.
    send(1, 14'h0200);
    @(posedge clk); #1;
    check("drop_no_output", 32'(out_valid), 32'h0);
    check("drop_err_1", 32'(err_count), 32'd1);
    for (int k = 0; k < 299; k++) send(1, 14'h0200);
    repeat (2) @(posedge clk); #1;
    check("drop_err_sat", 32'(err_count), 32'd255);
`endif

    // Randomized traffic with a reset in the middle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1500) mid_reset();
      for (int i = 0; i < 3; i++) begin
        if (!in_valid[i] || acc[i]) begin
          if ($urandom_range(0, 99) < 60) begin
            in_valid[i] = 1'b1;
            in_data[i] = mk(3'($urandom_range(0, 7)), i, seq[i]);
            seq[i] = seq[i] + 9'd1;
          end else begin
            in_valid[i] = 1'b0;
          end
        end
      end
      for (int o = 0; o < 3; o++) out_ready[o] = ($urandom_range(0, 9) < 7);
    end

    // Drain.
    @(posedge clk); #1;
    if (acc != 3'b000) begin
      for (int i = 0; i < 3; i++) if (acc[i]) in_valid[i] = 1'b0;
    end
    for (int t = 0; t < 20 && in_valid != 3'b000; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (acc[i]) in_valid[i] = 1'b0;
    end
    out_ready = 3'b111;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
`ifdef NOC_ROUTER_ERRCNT_EN
    check("err_count_final", 32'(err_count), (drops > 255) ? 32'd255 : 32'(drops));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_tree_router.md
NOC_TREE_ROUTER -- requirements
Module: noc_tree_router

Interface
REQ-001 SHALL have parameter WIDTH_PACKET, default 14, total packet width in bits.
REQ-002 SHALL have parameter WIDTH_DEST, default 3, destination-field width; the tree has 2**WIDTH_DEST leaf nodes.
REQ-003 SHALL have parameter LEVEL, default 2, router height above the leaves (1 = leaf-attached, WIDTH_DEST = root), legal range 1..WIDTH_DEST.
REQ-004 SHALL have parameter ROUTER_ADDR, default 0 (WIDTH_DEST bits), subtree prefix; only bits [WIDTH_DEST-1:LEVEL] are significant.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports parent_in_valid (input, 1), parent_in_data (input, WIDTH_PACKET) and parent_in_ready (output, 1), the packet input from the parent.
REQ-008 SHALL have ports child1_in_valid, child1_in_data and child1_in_ready, and child2_in_valid, child2_in_data and child2_in_ready, with the same directions and widths, the packet inputs from the children.
REQ-009 SHALL have ports parent_out_valid (output, 1), parent_out_data (output, WIDTH_PACKET) and parent_out_ready (input, 1), the packet output toward the parent.
REQ-010 SHALL have ports child1_out_valid, child1_out_data and child1_out_ready, and child2_out_valid, child2_out_data and child2_out_ready, with the same directions and widths, the packet outputs toward the children.
REQ-011 SHALL have port err_count, output, 8, misroute drop counter; this port exists only under NOC_ROUTER_ERRCNT_EN.

Function
REQ-012 SHALL treat a transfer as occurring on any rising edge where valid and ready are both high; the destination is dest = data[WIDTH_PACKET-1 -: WIDTH_DEST].
REQ-013 SHALL define the destination as in the subtree when dest[WIDTH_DEST-1:LEVEL] equals ROUTER_ADDR[WIDTH_DEST-1:LEVEL] (always true when LEVEL = WIDTH_DEST), and define sel = dest[LEVEL-1] (0 = child1, 1 = child2).
REQ-014 SHALL route parent-input packets to the child given by sel, with no subtree check.
REQ-015 SHALL route a child1-input packet to parent when it is out of the subtree, to child2 when it is in the subtree with sel = 1, and otherwise drop it as a misroute.
REQ-016 SHALL route a child2-input packet to parent when it is out of the subtree, to child1 when it is in the subtree with sel = 0, and otherwise drop it as a misroute.
REQ-017 SHALL give each input a 2-entry FIFO; in_ready SHALL be high while the FIFO holds fewer than 2 entries, and a push and a pop in the same cycle SHALL both occur.
REQ-018 SHALL drop a misrouted packet by popping it from the head of its FIFO in the cycle it reaches the head, with no output activity.
REQ-019 SHALL give each output a 1-entry output register that is loadable when empty or when it is being drained in the same cycle (out_valid and out_ready both high).
REQ-020 SHALL arbitrate each output between its two candidate input FIFO heads with 2-way round-robin: a sole requester wins; on contention the pointer-preferred requester wins, and after any grant the pointer SHALL favour the other requester.
REQ-021 SHALL have a latency of 2 rising edges: a packet accepted on edge N with an idle path SHALL show out_valid high after edge N+1.
REQ-022 SHALL sustain throughput of one packet per cycle per output and preserve FIFO order for each input-output pair.
REQ-023 SHALL hold out_data stable while out_valid is high and out_ready is low.

Reset
REQ-024 SHALL, while rst_n is low, immediately empty all FIFOs and output registers, drive all out_valid signals 0, all out_data signals 0 and all in_ready signals 0, and set err_count to 0.
REQ-025 SHALL reset the round-robin pointers to prefer child1 for parent_out, and parent for both child1_out and child2_out; in_ready SHALL go high on the first edge after rst_n deasserts, and packets in flight at reset are lost.

Configuration
REQ-026 SHALL, with NOC_ROUTER_ERRCNT_EN defined, provide err_count, incrementing it by 1 per misroute drop and saturating at 255.
REQ-027 SHALL, without NOC_ROUTER_ERRCNT_EN defined, omit the err_count port and counter, with drop behaviour unchanged.

Verification
REQ-028 SHALL cover: LEVEL=2, ROUTER_ADDR=3'b000, parent sends dest 3'b011 -> child2_out carries the packet 2 edges later, and the other outputs stay idle.
REQ-029 SHALL cover: child1 sends dest 3'b101 -> packet appears on parent_out; child1 sends dest 3'b010 -> packet appears on child2_out.
REQ-030 SHALL cover: child1 and child2 both send to parent on the same edge, with parent_out_ready held high -> child1's packet is output first, then child2's packet, in consecutive cycles.
REQ-031 SHALL cover: child1_out_ready held low while the parent sends 4 packets -> parent_in_ready falls after the 3rd accepted packet and no packet is lost or reordered once ready returns high.
REQ-032 SHALL cover: under NOC_ROUTER_ERRCNT_EN, child1 sends dest 3'b000 -> no output activity and err_count goes to 1; 300 such packets leave err_count at 255.
REQ-033 SHALL cover: rst_n asserted mid-stream -> all out_valid signals low immediately and err_count 0.
